// File: rtl/horner_eval.sv
// Sequential Horner-rule polynomial evaluator: acc <= acc*x + c for each accepted
// coefficient. Coefficients arrive over a valid/ready stream, and a one-cycle done pulse marks the result.
module horner_eval #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             coef_valid,
    input  logic [WIDTH-1:0] coef_data,
    output logic             coef_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] acc;
        logic             ovf;
    } step_t;

    // One Horner step, truncated to WIDTH bits; ovf flags any bit lost in the product or the add.
    function automatic step_t horner_step(input logic [WIDTH-1:0] acc_in,
                                          input logic [WIDTH-1:0] x_in,
                                          input logic [WIDTH-1:0] c_in);
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH:0]     sum;
        step_t              r;
        prod  = (2*WIDTH)'(acc_in) * (2*WIDTH)'(x_in);
        sum   = {1'b0, prod[WIDTH-1:0]} + {1'b0, c_in};
        r.acc = sum[WIDTH-1:0];
        r.ovf = (prod[2*WIDTH-1:WIDTH] != '0) | sum[WIDTH];
        return r;
    endfunction

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] x_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] cnt;

    step_t            step;
    logic [CNT_W-1:0] cnt_next;
    logic             xfer;

    always_comb begin
        step     = horner_step(acc, x_q, coef_data);
        cnt_next = cnt + 1'b1;
        xfer     = coef_ready & coef_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            x_q        <= '0;
            n_q        <= '0;
            result     <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            coef_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    coef_ready <= 1'b0;
                    if (start) begin
                        x_q      <= x;
                        n_q      <= n_terms;
                        acc      <= '0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (n_terms == '0) begin
                            // Empty polynomial: finish immediately with a zero result.
                            result <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            coef_ready <= 1'b1;
                            state      <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (xfer) begin
                        acc      <= step.acc;
                        cnt      <= cnt_next;
                        overflow <= overflow | step.ovf;
                        if (cnt_next == n_q) begin
                            result     <= step.acc;
                            coef_ready <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    coef_ready <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_horner_eval.sv
// Randomized self-checking bench for horner_eval against a plain-arithmetic polynomial model.
module tb_horner_eval;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [CNT_W-1:0] n_terms;
    logic             coef_valid;
    logic [WIDTH-1:0] coef_data;
    logic             coef_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    always #5 clk = ~clk;

    horner_eval #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .n_terms(n_terms),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] coef_mem [256];

    int               r_done_cycle;
    int               r_transfers;
    int               r_dones;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    bit               r_timeout;

    // Reference: evaluate with wide integers, overflow when any intermediate needs more than WIDTH bits.
    function automatic void ref_eval(input logic [WIDTH-1:0] rx, input int rn,
                                     output logic [WIDTH-1:0] res, output logic ovf);
        longint unsigned a, full;
        a   = 0;
        ovf = 1'b0;
        for (int i = 0; i < rn; i++) begin
            full = a * longint'(rx) + longint'(coef_mem[i]);
            if (full >= 64'd65536) ovf = 1'b1;
            a = full % 64'd65536;
        end
        res = a[WIDTH-1:0];
    endfunction

    // Drives one job; cycle 1 is the cycle right after the start edge.
    task automatic run_job(input logic [WIDTH-1:0] jx, input int jn, input int gap,
                           input bit rand_gap, input bit inject_start);
        int cycle, idx, gapcnt;
        r_done_cycle = -1; r_transfers = 0; r_dones = 0; r_timeout = 0;
        idx = 0; gapcnt = 0;
        @(negedge clk);
        start = 1'b1; x = jx; n_terms = jn[CNT_W-1:0]; coef_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cycle = 1;
        forever begin
            if (done) begin
                r_done_cycle = cycle; r_result = result; r_ovf = overflow; r_dones++;
                break;
            end
            if (cycle > 4000) begin
                r_timeout = 1;
                break;
            end
            if (inject_start && cycle == 2) begin
                start = 1'b1; x = 16'd9; n_terms = 8'd1;
            end else begin
                start = 1'b0;
            end
            if (idx < jn && gapcnt == 0) begin
                coef_valid = 1'b1; coef_data = coef_mem[idx];
            end else begin
                coef_valid = 1'b0; coef_data = WIDTH'($urandom);
            end
            if (coef_ready && coef_valid) begin
                r_transfers++; idx++;
                gapcnt = rand_gap ? int'($urandom_range(0, gap)) : gap;
            end else if (gapcnt > 0) begin
                gapcnt--;
            end
            @(negedge clk);
            cycle++;
        end
        start = 1'b0; coef_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) r_dones++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; x = '0; n_terms = '0; coef_valid = 1'b0; coef_data = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, coef_ready, overflow} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {busy, done, coef_ready, overflow});
        end
        n_checks++;
        if (result !== '0) begin
            n_fail++; $display("FAIL reset_result: got %h required 0000", result);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] er; logic eo;
        coef_mem[0] = 16'd1; coef_mem[1] = 16'd2; coef_mem[2] = 16'd3;
        ref_eval(16'd2, 3, er, eo);
        run_job(16'd2, 3, 0, 0, 0);
        n_checks++;
        if (r_timeout || r_result !== 16'd11 || r_result !== er) begin
            n_fail++; $display("FAIL basic_result: got %0d timeout=%0d required 11", r_result, r_timeout);
        end
        n_checks++;
        if (r_ovf !== eo) begin
            n_fail++; $display("FAIL basic_overflow: got %b required %b", r_ovf, eo);
        end
        n_checks++;
        if (r_done_cycle != 4 || r_transfers != 3 || r_dones != 1) begin
            n_fail++; $display("FAIL basic_timing: done_cycle=%0d transfers=%0d dones=%0d required 4/3/1",
                               r_done_cycle, r_transfers, r_dones);
        end
        n_checks++;
        if (busy !== 1'b0 || coef_ready !== 1'b0 || result !== 16'd11) begin
            n_fail++; $display("FAIL basic_hold: busy=%b ready=%b result=%0d required 0/0/11", busy, coef_ready, result);
        end
    endtask

    task automatic test_zero_terms();
        run_job(16'd7, 0, 0, 0, 0);
        n_checks++;
        if (r_done_cycle != 1 || r_transfers != 0 || r_dones != 1) begin
            n_fail++; $display("FAIL zero_timing: done_cycle=%0d transfers=%0d dones=%0d required 1/0/1",
                               r_done_cycle, r_transfers, r_dones);
        end
        n_checks++;
        if (r_result !== '0 || r_ovf !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_result: result=%h ovf=%b busy=%b required 0000/0/0", r_result, r_ovf, busy);
        end
    endtask

    task automatic test_overflow();
        coef_mem[0] = 16'h0100; coef_mem[1] = 16'h0000; coef_mem[2] = 16'h0000;
        run_job(16'h0100, 3, 0, 0, 0);
        n_checks++;
        if (r_result !== 16'h0000 || r_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set: result=%h ovf=%b required 0000/1", r_result, r_ovf);
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky_idle: got %b required 1", overflow);
        end
        coef_mem[0] = 16'd5;
        run_job(16'd1, 1, 0, 0, 0);
        n_checks++;
        if (r_result !== 16'd5 || r_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: result=%0d ovf=%b required 5/0", r_result, r_ovf);
        end
    endtask

    task automatic test_stalls();
        coef_mem[0] = 16'd1; coef_mem[1] = 16'd2; coef_mem[2] = 16'd3;
        run_job(16'd2, 3, 2, 0, 0);
        n_checks++;
        if (r_result !== 16'd11 || r_ovf !== 1'b0) begin
            n_fail++; $display("FAIL stall_result: result=%0d ovf=%b required 11/0", r_result, r_ovf);
        end
        n_checks++;
        if (r_done_cycle != 8 || r_transfers != 3 || r_dones != 1) begin
            n_fail++; $display("FAIL stall_timing: done_cycle=%0d transfers=%0d dones=%0d required 8/3/1",
                               r_done_cycle, r_transfers, r_dones);
        end
    endtask

    task automatic test_start_ignored();
        coef_mem[0] = 16'd1; coef_mem[1] = 16'd2; coef_mem[2] = 16'd3;
        run_job(16'd2, 3, 0, 0, 1);
        n_checks++;
        if (r_result !== 16'd11 || r_done_cycle != 4 || r_dones != 1) begin
            n_fail++; $display("FAIL start_ignored: result=%0d done_cycle=%0d dones=%0d required 11/4/1",
                               r_result, r_done_cycle, r_dones);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        start = 1'b1; x = 16'd2; n_terms = 8'd3;
        @(negedge clk);
        start = 1'b0; coef_valid = 1'b1; coef_data = 16'd1;
        @(negedge clk);
        coef_data = 16'd2;
        @(negedge clk);
        coef_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, coef_ready, overflow} !== 4'b0 || result !== '0) begin
            n_fail++; $display("FAIL midop_reset: ctrl=%b result=%h required 0000/0000",
                               {busy, done, coef_ready, overflow}, result);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || coef_ready !== 1'b0) begin
            n_fail++; $display("FAIL midop_idle: busy=%b ready=%b required 0/0", busy, coef_ready);
        end
        coef_mem[0] = 16'd1; coef_mem[1] = 16'd2; coef_mem[2] = 16'd3;
        run_job(16'd2, 3, 0, 0, 0);
        n_checks++;
        if (r_result !== 16'd11 || r_done_cycle != 4) begin
            n_fail++; $display("FAIL midop_rerun: result=%0d done_cycle=%0d required 11/4", r_result, r_done_cycle);
        end
    endtask

    task automatic test_max_terms();
        logic [WIDTH-1:0] er, jx; logic eo;
        jx = WIDTH'($urandom_range(0, 3));
        for (int i = 0; i < 255; i++) coef_mem[i] = WIDTH'($urandom);
        ref_eval(jx, 255, er, eo);
        run_job(jx, 255, 0, 0, 0);
        n_checks++;
        if (r_result !== er || r_ovf !== eo) begin
            n_fail++; $display("FAIL max_result: result=%h ovf=%b required %h/%b", r_result, r_ovf, er, eo);
        end
        n_checks++;
        if (r_done_cycle != 256 || r_transfers != 255 || r_dones != 1) begin
            n_fail++; $display("FAIL max_timing: done_cycle=%0d transfers=%0d dones=%0d required 256/255/1",
                               r_done_cycle, r_transfers, r_dones);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] er, jx; logic eo; int jn;
        for (int t = 0; t < 20; t++) begin
            jn = int'($urandom_range(1, 12));
            jx = (t % 2 == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
            for (int i = 0; i < jn; i++)
                coef_mem[i] = (t % 3 == 0) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom);
            ref_eval(jx, jn, er, eo);
            run_job(jx, jn, 3, 1, 0);
            n_checks++;
            if (r_timeout || r_result !== er || r_ovf !== eo || r_transfers != jn || r_dones != 1) begin
                n_fail++; $display("FAIL random_%0d: result=%h ovf=%b xfers=%0d dones=%0d required %h/%b/%0d/1",
                                   t, r_result, r_ovf, r_transfers, r_dones, er, eo, jn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_terms();
        test_overflow();
        test_stalls();
        test_start_ignored();
        test_reset_mid_op();
        test_max_terms();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
